// File: rtl/poly_mr_alpha_compose_pkg.sv
// Shared constants for the mod-alpha decompose/compose datapath.
package poly_mr_alpha_compose_pkg;

    localparam logic [23:0] Q      = 24'd8380417;
    localparam logic [23:0] ALPHA0 = 24'd190464;   // (q-1)/44
    localparam logic [23:0] ALPHA1 = 24'd523776;   // (q-1)/16
    localparam int unsigned R1_LIM0 = 44;
    localparam int unsigned R1_LIM1 = 16;

    function automatic logic is_alpha1(input logic [1:0] mode);
        return mode == 2'b11;
    endfunction

endpackage

// File: rtl/poly_mr_alpha_compose_mul_const.sv
// Combinational r1*alpha by shift-add; alpha chosen by the mode bit.
module mr_alpha_mul_const #(
    parameter int unsigned R1_W = 6,
    parameter int unsigned P_W  = 25
) (
    input  logic [R1_W-1:0] i_r1,
    input  logic            i_alpha1,
    output logic [P_W-1:0]  o_prod
);

    logic [P_W-1:0] w_r1;

    assign w_r1 = P_W'(i_r1);

    // alpha1 = 2^19 - 2^9, alpha0 = 2^17 + 2^16 - 2^12 - 2^11
    always_comb begin
        o_prod = '0;
        if (i_alpha1)
            o_prod = (w_r1 << 19) - (w_r1 << 9);
        else
            o_prod = (w_r1 << 17) + (w_r1 << 16) - (w_r1 << 12) - (w_r1 << 11);
    end

endmodule

// File: rtl/poly_mr_alpha_compose.sv
// Rebuilds r = (r1*alpha + r0) mod q in a 2-stage valid/ready pipeline.
module poly_mr_alpha_compose
    import poly_mr_alpha_compose_pkg::*;
#(
    parameter int unsigned Q_W  = 24,
    parameter int unsigned R1_W = 6,
    parameter int unsigned R0_W = 20
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      decompose,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [R1_W-1:0] r1_i,
    input  logic [R0_W-1:0] r0_i,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [Q_W-1:0]  r_o,
    output logic            r1_err_o
);

    localparam int unsigned S_W = Q_W + 1;

    logic            w_alpha1;
    logic            w_err;
    logic            w_s2_free;
    logic [S_W-1:0]  w_prod;
    logic [S_W-1:0]  w_sum;
    logic [Q_W-1:0]  w_fix;

    logic            r_s1_valid;
    logic            r_s1_err;
    logic [S_W-1:0]  r_s1_prod;
    logic [S_W-1:0]  r_s1_r0;
    logic            r_s2_valid;
    logic            r_s2_err;
    logic [Q_W-1:0]  r_s2_r;

    assign w_alpha1 = is_alpha1(decompose);
    assign w_err    = w_alpha1 ? (32'(r1_i) >= R1_LIM1) : (32'(r1_i) >= R1_LIM0);

    mr_alpha_mul_const #(
        .R1_W (R1_W),
        .P_W  (S_W)
    ) u_mul (
        .i_r1     (r1_i),
        .i_alpha1 (w_alpha1),
        .o_prod   (w_prod)
    );

    assign w_s2_free = ~r_s2_valid | out_ready;
    assign in_ready  = ~r_s1_valid | w_s2_free;

    // Negative sums only occur for r1=0, r0<0; adding q in Q_W bits is exact modulo 2^Q_W.
    assign w_sum = r_s1_prod + r_s1_r0;
    assign w_fix = w_sum[S_W-1] ? (w_sum[Q_W-1:0] + Q_W'(Q)) : w_sum[Q_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_err   <= 1'b0;
            r_s1_prod  <= '0;
            r_s1_r0    <= '0;
            r_s2_valid <= 1'b0;
            r_s2_err   <= 1'b0;
            r_s2_r     <= '0;
        end else begin
            if (in_ready) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_prod <= w_prod;
                    r_s1_r0   <= S_W'(signed'(r0_i));
                    r_s1_err  <= w_err;
                end
            end
            if (w_s2_free) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_err <= r_s1_err;
                    r_s2_r   <= r_s1_err ? '0 : w_fix;
                end
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign r_o       = r_s2_r;
    assign r1_err_o  = r_s2_err;

endmodule

// File: tb/tb_poly_mr_alpha_compose.sv
// Directed + randomized scoreboard bench for poly_mr_alpha_compose.
module tb_poly_mr_alpha_compose;

    localparam int QV = 8380417;
    localparam int A0 = 190464;
    localparam int A1 = 523776;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  decompose = 2'b00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  r1_i = '0;
    logic [19:0] r0_i = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [23:0] r_o;
    logic        r1_err_o;

    int          total = 0;
    int          bad = 0;
    logic        rand_bp = 1'b0;
    logic [24:0] exq[$];

    poly_mr_alpha_compose #(
        .Q_W  (24),
        .R1_W (6),
        .R0_W (20)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .decompose (decompose),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .r1_i      (r1_i),
        .r0_i      (r0_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r_o       (r_o),
        .r1_err_o  (r1_err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [24:0] expect_ok(input int r);
        logic [23:0] v;
        v = 24'(r);
        return {1'b0, v};
    endfunction

    // Independent modular reference: plain multiply, range check, wrap by +q.
    function automatic logic [24:0] model(input logic [1:0] m, input int r1, input int r0);
        longint a;
        longint s;
        int     lim;
        a   = (m == 2'b11) ? A1 : A0;
        lim = (m == 2'b11) ? 16 : 44;
        if (r1 >= lim) return {1'b1, 24'd0};
        s = r1 * a + r0;
        if (s < 0) s = s + QV;
        return {1'b0, 24'(s)};
    endfunction

    task automatic decomp(input logic [1:0] m, input int r, output int r1, output int r0);
        int a;
        a  = (m == 2'b11) ? A1 : A0;
        r0 = r % a;
        if (r0 > a / 2) r0 = r0 - a;
        if (r - r0 == QV - 1) begin
            r1 = 0;
            r0 = r0 - 1;
        end else begin
            r1 = (r - r0) / a;
        end
    endtask

    task automatic send(input logic [1:0] m, input int r1, input int r0, input logic [24:0] exp);
        int   tries;
        logic acc;
        tries     = 0;
        acc       = 1'b0;
        decompose = m;
        r1_i      = r1[5:0];
        r0_i      = r0[19:0];
        in_valid  = 1'b1;
        while (!acc && tries < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            tries++;
            if (rand_bp) out_ready = 1'($urandom_range(0, 1));
        end
        if (acc) exq.push_back(exp);
        else check("accept_timeout", acc, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n         = 0;
        out_ready = 1'b1;
        while (exq.size() > 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_empty", exq.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exq.size() == 0) begin
                check("out_unexpected", out_valid, 0);
            end else begin
                logic [24:0] e;
                e = exq.pop_front();
                check("r_o", r_o, e[23:0]);
                check("r1_err_o", r1_err_o, e[24]);
            end
        end
    end

    initial begin
        int r1, r0, r;
        logic [1:0] m;
        logic [24:0] b0;

        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_r_o", r_o, 0);
        check("rst_err", r1_err_o, 0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);

        // Latency: accepted on edge e0, visible at output after e1
        send(2'b11, 15, 261888, expect_ok(8118528));
        check("lat_s1", out_valid, 0);
        @(posedge clk);
        #1;
        check("lat_s2", out_valid, 1);
        check("lat_r_o", r_o, 8118528);
        drain();

        send(2'b11, 0, -1, expect_ok(8380416));
        send(2'b00, 5, -95233, expect_ok(857087));
        send(2'b00, 43, 95232, expect_ok(8285184));
        send(2'b00, 44, 5, {1'b1, 24'd0});
        send(2'b11, 16, 100, {1'b1, 24'd0});
        send(2'b01, 63, 0, {1'b1, 24'd0});
        send(2'b11, 15, -261889, expect_ok(7594751));
        drain();

        // Backpressure with two beats held
        out_ready = 1'b1;
        b0 = model(2'b00, 1, 10);
        send(2'b00, 1, 10, b0);
        send(2'b10, 2, 20, model(2'b10, 2, 20));
        out_ready = 1'b0;
        decompose = 2'b11;
        r1_i      = 6'd3;
        r0_i      = 20'd30;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            check("bp_r_o_stable", r_o, b0[23:0]);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        send(2'b11, 3, 30, model(2'b11, 3, 30));
        send(2'b00, 4, -40, model(2'b00, 4, -40));
        drain();

        // Alternating modes back to back
        for (int i = 0; i < 6; i++) begin
            m = (i % 2 == 0) ? 2'b11 : 2'b00;
            send(m, 10, 1000, model(m, 10, 1000));
        end
        drain();

        // Reset with two beats in flight
        send(2'b11, 7, 7, model(2'b11, 7, 7));
        send(2'b00, 8, 8, model(2'b00, 8, 8));
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_r_o", r_o, 0);
        exq.delete();
        #3 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_stale", out_valid, 0);
        end
        @(posedge clk);
        #1;
        send(2'b11, 1, 1, expect_ok(523777));
        drain();

        // Decompose then compose must reproduce r
        rand_bp = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            m = 2'($urandom_range(0, 3));
            if (i < 4) r = (i < 2) ? QV - 1 - i : i - 2;
            else if (i < 40) r = QV - 1 - int'($urandom_range(0, 300000));
            else r = int'($urandom_range(0, QV - 1));
            decomp(m, r, r1, r0);
            send(m, r1, r0, expect_ok(r));
        end
        rand_bp = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
